// File: rtl/axi_rd_arbiter.sv
// Two-port round-robin arbiter onto a single AXI4 read master (AR/R channels).
// One burst outstanding at a time; R beats are routed to the owner and checked for count/ID/RLAST consistency.
module axi_rd_arbiter #(
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32,
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ARUSER_WIDTH    = 1,
    parameter int C_M_AXI_RUSER_WIDTH     = 1
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic                               R0_REQ,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      R0_ADDR,
    input  logic [7:0]                         R0_LEN,
    output logic                               R0_ACK,
    output logic                               R0_VALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      R0_DATA,
    output logic                               R0_LAST,
    output logic                               R0_ERR,
    input  logic                               R1_REQ,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      R1_ADDR,
    input  logic [7:0]                         R1_LEN,
    output logic                               R1_ACK,
    output logic                               R1_VALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      R1_DATA,
    output logic                               R1_LAST,
    output logic                               R1_ERR,
    output logic                               PROTO_ERR,
    output logic                               BUSY,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARLOCK,
    output logic [3:0]                         M_AXI_ARCACHE,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic [3:0]                         M_AXI_ARQOS,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic [C_M_AXI_RUSER_WIDTH-1:0]     M_AXI_RUSER,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                          state_q, state_d;
    logic                            owner_q, last_owner_q, grant;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]                      len_q;
    logic [8:0]                      cnt_q;
    logic                            perr_q, perr_set, any_req, beat_acc;

    assign any_req = R0_REQ | R1_REQ;
    // On a tie the port that did not own the previous burst wins.
    assign grant   = (R0_REQ & R1_REQ) ? ~last_owner_q : R1_REQ;
    assign beat_acc = (state_q == DATA) & M_AXI_RVALID;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ADDR;
            ADDR:    if (M_AXI_ARREADY) state_d = DATA;
            DATA:    if (M_AXI_RVALID && M_AXI_RLAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign perr_set = (beat_acc && M_AXI_RLAST && cnt_q != {1'b0, len_q})
                    | (beat_acc && !M_AXI_RLAST && cnt_q == {1'b0, len_q})
                    | (beat_acc && M_AXI_RID != M_AXI_ARID)
                    | (M_AXI_RVALID && state_q != DATA);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            perr_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                cnt_q <= '0;
                if (any_req) begin
                    owner_q      <= grant;
                    last_owner_q <= grant;
                    addr_q       <= grant ? R1_ADDR : R0_ADDR;
                    len_q        <= grant ? R1_LEN  : R0_LEN;
                end
            end else if (beat_acc) begin
                cnt_q <= cnt_q + 9'd1;
            end
            if (perr_set) perr_q <= 1'b1;
        end
    end

    // ARVALID comes straight from the state register, so it is glitch-free and stable until handshake.
    assign M_AXI_ARVALID = (state_q == ADDR);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = len_q;
    assign M_AXI_ARID    = C_M_AXI_THREAD_ID_WIDTH'(owner_q);
    assign M_AXI_ARSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARUSER  = '0;
    assign M_AXI_RREADY  = (state_q == DATA);

    assign R0_ACK   = M_AXI_ARVALID & M_AXI_ARREADY & ~owner_q;
    assign R1_ACK   = M_AXI_ARVALID & M_AXI_ARREADY &  owner_q;
    assign R0_VALID = beat_acc & ~owner_q;
    assign R1_VALID = beat_acc &  owner_q;
    assign R0_DATA  = M_AXI_RDATA;
    assign R1_DATA  = M_AXI_RDATA;
    assign R0_LAST  = R0_VALID & M_AXI_RLAST;
    assign R1_LAST  = R1_VALID & M_AXI_RLAST;
    assign R0_ERR   = R0_VALID & M_AXI_RRESP[1];
    assign R1_ERR   = R1_VALID & M_AXI_RRESP[1];

    assign PROTO_ERR = perr_q;
    assign BUSY      = (state_q != IDLE);

    logic unused_sig;
    assign unused_sig = &{1'b0, M_AXI_RRESP[0], M_AXI_RUSER};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: drives AR/R slave side and both requesters.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    logic        ACLK = 0, ARESETN = 0;
    logic        R0_REQ = 0, R1_REQ = 0;
    logic [31:0] R0_ADDR = 0, R1_ADDR = 0;
    logic [7:0]  R0_LEN = 0, R1_LEN = 0;
    logic        R0_ACK, R0_VALID, R0_LAST, R0_ERR;
    logic        R1_ACK, R1_VALID, R1_LAST, R1_ERR;
    logic [31:0] R0_DATA, R1_DATA;
    logic        PROTO_ERR, BUSY;
    logic [0:0]  M_AXI_ARID, M_AXI_ARUSER;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE, M_AXI_ARPROT;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARLOCK, M_AXI_ARVALID, M_AXI_RREADY;
    logic [3:0]  M_AXI_ARCACHE, M_AXI_ARQOS;
    logic        M_AXI_ARREADY = 0;
    logic [0:0]  M_AXI_RID = 0, M_AXI_RUSER = 0;
    logic [31:0] M_AXI_RDATA = 0;
    logic [1:0]  M_AXI_RRESP = 0;
    logic        M_AXI_RLAST = 0, M_AXI_RVALID = 0;

    axi_rd_arbiter dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .R0_REQ(R0_REQ), .R0_ADDR(R0_ADDR), .R0_LEN(R0_LEN), .R0_ACK(R0_ACK),
        .R0_VALID(R0_VALID), .R0_DATA(R0_DATA), .R0_LAST(R0_LAST), .R0_ERR(R0_ERR),
        .R1_REQ(R1_REQ), .R1_ADDR(R1_ADDR), .R1_LEN(R1_LEN), .R1_ACK(R1_ACK),
        .R1_VALID(R1_VALID), .R1_DATA(R1_DATA), .R1_LAST(R1_LAST), .R1_ERR(R1_ERR),
        .PROTO_ERR(PROTO_ERR), .BUSY(BUSY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        last;
        logic        err;
    } beat_t;

    beat_t sb[$];
    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic do_reset();
        ARESETN = 0;
        repeat (2) @(posedge ACLK);
        #2 ARESETN = 1;
    endtask

    // Entered mid-cycle with the DUT in IDLE and the request(s) already driven.
    task automatic do_addr(input int p, input logic [31:0] a, input logic [7:0] l, input int stall);
        #1;
        chk("arvalid_idle", M_AXI_ARVALID, 0);
        tick(); #1;
        chk("arvalid_rise", M_AXI_ARVALID, 1);
        chk("araddr", M_AXI_ARADDR, a);
        chk("arlen", M_AXI_ARLEN, l);
        chk("arid", M_AXI_ARID, p);
        for (int s = 0; s < stall; s++) begin
            chk("ack_stall", R0_ACK | R1_ACK, 0);
            tick(); #1;
            chk("arvalid_hold", M_AXI_ARVALID, 1);
            chk("araddr_hold", M_AXI_ARADDR, a);
            chk("arlen_hold", M_AXI_ARLEN, l);
        end
        M_AXI_ARREADY = 1;
        #1;
        chk("ack_owner", (p == 1) ? R1_ACK : R0_ACK, 1);
        chk("ack_other", (p == 1) ? R0_ACK : R1_ACK, 0);
        tick();
        M_AXI_ARREADY = 0;
    endtask

    task automatic do_data(input int p, input int nb, input int last_at, input int err_at);
        beat_t e;
        for (int i = 0; i < nb; i++) begin
            M_AXI_RVALID = 1;
            M_AXI_RID    = 1'(p);
            M_AXI_RDATA  = $urandom;
            M_AXI_RLAST  = (i == last_at);
            M_AXI_RRESP  = (i == err_at) ? 2'b10 : 2'b00;
            sb.push_back('{port: p, data: M_AXI_RDATA, last: M_AXI_RLAST, err: (i == err_at)});
            #1;
            chk("rready", M_AXI_RREADY, 1);
            if ((R0_VALID || R1_VALID) && sb.size() > 0) begin
                e = sb.pop_front();
                chk("beat_port", R1_VALID, e.port);
                chk("beat_both", R0_VALID & R1_VALID, 0);
                chk("beat_data", R1_VALID ? R1_DATA : R0_DATA, e.data);
                chk("beat_last", R1_VALID ? R1_LAST : R0_LAST, e.last);
                chk("beat_err", R1_VALID ? R1_ERR : R0_ERR, e.err);
            end else begin
                chk("beat_seen", 0, 1);
                if (sb.size() > 0) void'(sb.pop_front());
            end
            tick();
        end
        M_AXI_RVALID = 0;
        M_AXI_RLAST  = 0;
        M_AXI_RRESP  = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        #1;
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_perr", PROTO_ERR, 0);
        chk("rst_ack", {R0_ACK, R1_ACK}, 0);
        chk("rst_valid", {R0_VALID, R1_VALID}, 0);
        chk("rst_araddr", M_AXI_ARADDR, 0);
        chk("rst_arlen", M_AXI_ARLEN, 0);
        chk("rst_arid", M_AXI_ARID, 0);
        chk("arsize", M_AXI_ARSIZE, 2);
        chk("arburst", M_AXI_ARBURST, 1);
        chk("arcache", M_AXI_ARCACHE, 3);
        chk("ar_zero_fields", {M_AXI_ARLOCK, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER}, 0);

        // single R0 burst of 4 beats
        R0_REQ = 1; R0_ADDR = 32'h1000; R0_LEN = 8'd3;
        do_addr(0, 32'h1000, 8'd3, 0);
        R0_REQ = 0;
        chk("busy_data", BUSY, 1);
        do_data(0, 4, 3, -1);
        #1;
        chk("busy_done", BUSY, 0);
        chk("perr_clean", PROTO_ERR, 0);

        // tie after reset: alternate starting with port 0
        tick();
        do_reset();
        R0_REQ = 1; R0_ADDR = 32'h100; R0_LEN = 0;
        R1_REQ = 1; R1_ADDR = 32'h200; R1_LEN = 0;
        for (int k = 0; k < 4; k++) begin
            do_addr(k % 2, (k % 2) ? 32'h200 : 32'h100, 8'd0, 0);
            do_data(k % 2, 1, 0, -1);
        end
        R0_REQ = 0; R1_REQ = 0;

        // R1 with 5-cycle ARREADY stall, SLVERR on first beat only
        tick();
        R1_REQ = 1; R1_ADDR = 32'h2000; R1_LEN = 8'd1;
        do_addr(1, 32'h2000, 8'd1, 5);
        R1_REQ = 0;
        do_data(1, 2, 1, 0);
        #1;
        chk("perr_after_slverr", PROTO_ERR, 0);

        // early RLAST on beat 2 of LEN=3
        tick();
        R0_REQ = 1; R0_ADDR = 32'h3000; R0_LEN = 8'd3;
        do_addr(0, 32'h3000, 8'd3, 0);
        R0_REQ = 0;
        do_data(0, 2, 1, -1);
        #1;
        chk("perr_early_last", PROTO_ERR, 1);
        chk("idle_after_early", BUSY, 0);
        tick(); tick(); #1;
        chk("perr_sticky", PROTO_ERR, 1);

        // async reset mid-burst on beat 2 of 8
        tick();
        R0_REQ = 1; R0_ADDR = 32'h4000; R0_LEN = 8'd7;
        do_addr(0, 32'h4000, 8'd7, 0);
        R0_REQ = 0;
        do_data(0, 1, -1, -1);
        M_AXI_RVALID = 1; M_AXI_RID = 0; M_AXI_RDATA = 32'hdead_beef;
        ARESETN = 0;
        #1;
        chk("mid_rst_valid", {R0_VALID, R1_VALID, R0_LAST, R0_ERR}, 0);
        chk("mid_rst_rready", M_AXI_RREADY, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_perr", PROTO_ERR, 0);
        chk("mid_rst_arvalid", M_AXI_ARVALID, 0);
        M_AXI_RVALID = 0;
        tick();
        ARESETN = 1;
        R0_REQ = 1; R0_ADDR = 32'h5000; R0_LEN = 0;
        do_addr(0, 32'h5000, 8'd0, 0);
        R0_REQ = 0;
        do_data(0, 1, 0, -1);
        #1;
        chk("perr_post_rst", PROTO_ERR, 0);

        // stray RVALID while idle: not accepted, flagged
        tick();
        M_AXI_RVALID = 1;
        #1;
        chk("stray_rready", M_AXI_RREADY, 0);
        chk("stray_valid", {R0_VALID, R1_VALID}, 0);
        tick();
        M_AXI_RVALID = 0;
        #1;
        chk("perr_stray", PROTO_ERR, 1);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares the core's single AXI4 read master port (AR/R channels) between two requesters: port 0, the instruction fetch unit, and port 1, a data-load unit for later pipeline stages. The block grants one read burst at a time using round-robin priority. It drives the AR channel, routes R beats back to the owning requester, and checks beat count and response codes. It sits between the requesters and the M_AXI_AR*/M_AXI_R* ports of the core.

## Interface
- C_M_AXI_ADDR_WIDTH, 32: address width.
- C_M_AXI_DATA_WIDTH, 32: data width; ARSIZE is derived as log2(C_M_AXI_DATA_WIDTH/8).
- C_M_AXI_THREAD_ID_WIDTH, 1: ARID/RID width; must be ≥1.
- ACLK  in  1  single clock for the whole block.
- ARESETN  in  1  asynchronous, active-low reset.
- Rn_REQ  in  1  (n = 0,1) request; held high until Rn_ACK.
- Rn_ADDR  in  ADDR_WIDTH  burst start address; stable while Rn_REQ is high.
- Rn_LEN  in  8  AXI ARLEN (beats − 1); stable while Rn_REQ is high.
- Rn_ACK  out  1  one-cycle pulse when this requester's AR handshake completes.
- Rn_VALID  out  1  read beat valid for requester n; no backpressure.
- Rn_DATA  out  DATA_WIDTH  read beat data (M_AXI_RDATA passthrough).
- Rn_LAST  out  1  final beat of the burst.
- Rn_ERR  out  1  the current beat has RRESP ≠ OKAY.
- PROTO_ERR  out  1  sticky beat-count/RLAST mismatch flag; cleared only by reset.
- BUSY  out  1  high whenever state ≠ IDLE.
- M_AXI_AR*  out  —  full AR channel (ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT, QOS, USER, VALID); M_AXI_ARREADY in.
- M_AXI_R*  in  —  RID, RDATA, RRESP, RLAST, RUSER, RVALID; M_AXI_RREADY out.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any Rn_REQ is high, select an owner, latch its ADDR and LEN, then go to ADDR.
  - Clear the beat counter.
- Arbitration:
  - With a single request, that requester is granted.
  - With both requesting, grant the requester that was not the previous owner.
  - The last-owner register resets to 1, so port 0 wins the first tie.
- ADDR:
  - M_AXI_ARVALID = 1, with ARADDR/ARLEN taken from the latched values and ARID = owner index.
  - On ARVALID && ARREADY: Rn_ACK = 1 for the owner in that same cycle; go to DATA.
- DATA:
  - M_AXI_RREADY = 1.
  - Owner's Rn_VALID = M_AXI_RVALID; Rn_DATA, Rn_LAST, Rn_ERR (RRESP[1]) pass through combinationally.
  - The other port's VALID/LAST/ERR are 0.
  - Each accepted beat increments the 9-bit beat counter.
  - When a beat with RLAST is accepted, go to IDLE.
- Constant AR fields:
  - ARBURST = 2'b01 (INCR), ARLOCK = 0, ARCACHE = 4'b0011, ARPROT = 0, ARQOS = 0, ARUSER = 0.
- Protocol checks:
  - PROTO_ERR is set if RLAST arrives when count ≠ latched LEN.
  - PROTO_ERR is set if count reaches LEN and the beat lacks RLAST; the FSM still waits for RLAST.
  - PROTO_ERR is set if RID ≠ owner index.
  - PROTO_ERR is set if RVALID is high outside DATA; that beat is not accepted (RREADY = 0).
- Only one transaction is outstanding at a time. 4 KB boundary compliance and address alignment are the requester's responsibility.

## Timing
- Reset (ARESETN low, asynchronous):
  - State goes to IDLE.
  - ARVALID, RREADY, all Rn_ACK/VALID/LAST/ERR, PROTO_ERR and BUSY go to 0.
  - ARADDR/ARLEN/ARID latches go to 0; last owner goes to 1.
- Reset mid-burst aborts the burst; requesters must re-request after reset.
- ARVALID is registered: it rises one cycle after Rn_REQ is sampled in IDLE, so the AR latency is 1 cycle plus ARREADY wait.
- ARVALID, ARADDR, ARLEN and ARID stay stable from ARVALID rise until the handshake.
- RLAST handshake at cycle t puts the FSM in IDLE at t+1. If a request is pending, ARVALID is high again at t+2.
- REQ deasserted before ACK is a requester protocol violation. The arbiter still completes the latched transaction.
- Simultaneous new REQ on the ACK cycle of the other port: the new request waits until IDLE.

## Test plan
- Single request: R0_REQ with ADDR = 0x1000, LEN = 3, ARREADY = 1 -> ARVALID one cycle later with ARADDR 0x1000, ARLEN 3, ARID 0; R0_ACK 1 cycle; 4 beats on R0_VALID, R0_LAST on the 4th; R1_VALID stays 0.
- Tie after reset: R0 and R1 requesting at the same time, LEN = 0 -> first grant to port 0, then port 1, then port 0 (alternation over 4 bursts).
- ARREADY stall of 5 cycles -> ARVALID, ARADDR and ARLEN constant for 6 cycles; ACK only in the handshake cycle.
- Error paths:
  - Beat with RRESP = 2'b10 -> R1_ERR high on that beat only.
  - RLAST on beat 2 of a LEN = 3 burst -> PROTO_ERR sticky, FSM returns to IDLE.
- Async reset asserted mid-burst (beat 2 of 8) -> all outputs 0 immediately; after release, a new R0_REQ is served normally with ARID 0.
